// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port RAM between instr fetch, CPU data and keypad/LCD FSM.
// Latency: request-to-hit 4 cycles at zero wait, +1 per extra busy cycle; one transaction per 5 cycles.
// Backpressure: level-held requests wait in IDLE; RAM busy_i stalls WAIT until done or TIMEOUT abort.
module mem_arbiter #(
    parameter int AW      = 12,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          nRST,
    input  logic          iread,
    input  logic [31:0]   iaddr,
    output logic          ihit,
    output logic [31:0]   idata,
    input  logic          dread,
    input  logic          dwrite,
    input  logic [31:0]   daddr,
    input  logic [31:0]   dwdata,
    input  logic [3:0]    dsel,
    output logic          dhit,
    output logic [31:0]   drdata,
    input  logic          aread,
    input  logic          awrite,
    input  logic [31:0]   aaddr,
    input  logic [31:0]   awdata,
    input  logic [3:0]    asel,
    output logic          ahit,
    output logic [31:0]   ardata,
    output logic          read_o,
    output logic          write_o,
    output logic [AW-1:0] adr_o,
    output logic [31:0]   dat_o,
    output logic [3:0]    sel_o,
    input  logic [31:0]   dat_i,
    input  logic          busy_i,
    output logic          err_o,
    output logic [1:0]    grant_o
);
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t        state;
    logic [1:0]    owner;
    logic [1:0]    last_grant;
    logic [1:0]    nxt;
    logic          op_wr;
    logic [CW-1:0] cnt;
    logic [3:0]    pend;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_sel;
    logic          req_wr;
    logic          ram_done;
    logic          tmo_done;
    logic          unused_addr_hi;

    // Requester codes match grant_o: 1 instr, 2 data, 3 FSM; bit 0 (no owner) is never pending.
    assign pend = {aread | awrite, dread | dwrite, iread, 1'b0};

    function automatic logic [1:0] rr_next(input logic [1:0] last, input logic [3:0] p);
        logic [1:0] c;
        logic [1:0] r;
        c = last;
        r = 2'd0;
        for (int k = 0; k < 3; k++) begin
            c = (c == 2'd3 || c == 2'd0) ? 2'd1 : c + 2'd1;
            if (p[c] && r == 2'd0) r = c;
        end
        return r;
    endfunction

    assign nxt = rr_next(last_grant, pend);

    always_comb begin
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_sel   = 4'h0;
        req_wr    = 1'b0;
        case (nxt)
            2'd1: begin
                req_addr = iaddr;
                req_sel  = 4'hF;
            end
            2'd2: begin
                req_addr  = daddr;
                req_wdata = dwdata;
                req_sel   = dsel;
                req_wr    = dwrite;
            end
            2'd3: begin
                req_addr  = aaddr;
                req_wdata = awdata;
                req_sel   = asel;
                req_wr    = awrite;
            end
            default: ;
        endcase
    end

    assign unused_addr_hi = |req_addr[31:AW];

    // busy_i is not trusted in the first WAIT cycle (cnt == 0); completion beats a same-cycle timeout.
    assign ram_done = (state == S_WAIT) && (cnt != '0) && !busy_i;
    assign tmo_done = (state == S_WAIT) && !ram_done && (cnt == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state      <= S_IDLE;
            owner      <= 2'd0;
            last_grant <= 2'd3;
            op_wr      <= 1'b0;
            cnt        <= '0;
            grant_o    <= 2'd0;
            read_o     <= 1'b0;
            write_o    <= 1'b0;
            adr_o      <= '0;
            dat_o      <= 32'h0;
            sel_o      <= 4'h0;
            ihit       <= 1'b0;
            dhit       <= 1'b0;
            ahit       <= 1'b0;
            err_o      <= 1'b0;
            idata      <= 32'h0;
            drdata     <= 32'h0;
            ardata     <= 32'h0;
        end else begin
            ihit    <= 1'b0;
            dhit    <= 1'b0;
            ahit    <= 1'b0;
            err_o   <= 1'b0;
            read_o  <= 1'b0;
            write_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (nxt != 2'd0) begin
                        owner      <= nxt;
                        grant_o    <= nxt;
                        last_grant <= nxt;
                        op_wr      <= req_wr;
                        adr_o      <= req_addr[AW-1:0];
                        dat_o      <= req_wdata;
                        sel_o      <= req_sel;
                        read_o     <= !req_wr;
                        write_o    <= req_wr;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (ram_done && !op_wr) begin
                        case (owner)
                            2'd1:    idata  <= dat_i;
                            2'd2:    drdata <= dat_i;
                            2'd3:    ardata <= dat_i;
                            default: ;
                        endcase
                    end
                    if (ram_done || tmo_done) begin
                        ihit    <= (owner == 2'd1);
                        dhit    <= (owner == 2'd2);
                        ahit    <= (owner == 2'd3);
                        err_o   <= tmo_done;
                        grant_o <= 2'd0;
                        state   <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written reset-in-WAIT sequence,
// and randomized requests checked against a transaction-level round-robin/RAM model.
module tb_mem_arbiter;
    localparam int AW      = 12;
    localparam int TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          nRST;
    logic          iread, dread, dwrite, aread, awrite;
    logic [31:0]   iaddr, daddr, dwdata, aaddr, awdata;
    logic [3:0]    dsel, asel;
    logic          ihit, dhit, ahit;
    logic [31:0]   idata, drdata, ardata;
    logic          read_o, write_o;
    logic [AW-1:0] adr_o;
    logic [31:0]   dat_o;
    logic [3:0]    sel_o;
    logic [31:0]   dat_i;
    logic          busy_i;
    logic          err_o;
    logic [1:0]    grant_o;

    mem_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .nRST(nRST),
        .iread(iread), .iaddr(iaddr), .ihit(ihit), .idata(idata),
        .dread(dread), .dwrite(dwrite), .daddr(daddr), .dwdata(dwdata), .dsel(dsel),
        .dhit(dhit), .drdata(drdata),
        .aread(aread), .awrite(awrite), .aaddr(aaddr), .awdata(awdata), .asel(asel),
        .ahit(ahit), .ardata(ardata),
        .read_o(read_o), .write_o(write_o), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
        .dat_i(dat_i), .busy_i(busy_i), .err_o(err_o), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    logic [31:0] ram     [4096];
    logic [31:0] ref_mem [4096];
    int          busy_left, extra_busy, model_last;
    int          checks, errors;
    logic [31:0] e_idata, e_drdata, e_ardata;

    typedef struct {
        logic [4:0]  req;    // {iread, dread, dwrite, aread, awrite}
        logic [31:0] addr;   // iaddr; daddr = addr+4; aaddr = addr+8
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          extra;  // extra busy cycles
        bit          tmo;    // hold busy forever
        int          exp_grant;
    } vec_t;
    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock; the RAM model reacts to the strobes seen during the cycle just ended.
    task automatic tick();
        logic          s_wr, s_rd;
        logic [AW-1:0] s_adr;
        logic [31:0]   s_dat;
        logic [3:0]    s_sel;
        s_wr  = write_o;
        s_rd  = read_o;
        s_adr = adr_o;
        s_dat = dat_o;
        s_sel = sel_o;
        @(posedge clk);
        #1;
        if (s_wr)
            for (int b = 0; b < 4; b++)
                if (s_sel[b]) ram[s_adr][8*b +: 8] = s_dat[8*b +: 8];
        if (s_wr || s_rd) busy_left = 1 + extra_busy;
        else if (busy_left > 0) busy_left--;
        busy_i = (busy_left != 0);
        dat_i  = ram[adr_o];
    endtask

    function automatic int rr_pick(input int last, input logic [2:0] pend);
        int c;
        c = last;
        for (int k = 0; k < 3; k++) begin
            c = (c % 3) + 1;
            if (pend[c-1]) return c;
        end
        return 0;
    endfunction

    task automatic set_reqs(input logic [4:0] r, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] s);
        {iread, dread, dwrite, aread, awrite} = r;
        iaddr  = a;
        daddr  = a + 32'd4;
        aaddr  = a + 32'd8;
        dwdata = wd;
        awdata = wd;
        dsel   = s;
        asel   = s;
    endtask

    task automatic rand_reqs();
        iread  = 1'($urandom_range(0, 1));
        dread  = 1'($urandom_range(0, 1));
        dwrite = 1'($urandom_range(0, 1));
        aread  = 1'($urandom_range(0, 1));
        awrite = 1'($urandom_range(0, 1));
        iaddr  = $urandom;
        daddr  = $urandom;
        aaddr  = $urandom;
        dwdata = $urandom;
        awdata = $urandom;
        dsel   = 4'($urandom_range(0, 15));
        asel   = 4'($urandom_range(0, 15));
    endtask

    // Called in an IDLE cycle with requests already on the inputs; returns in the next IDLE cycle.
    task automatic do_txn(input int exp_g, input int extra, input bit tmo, input bit scramble);
        logic [AW-1:0] a;
        logic [31:0]   wd, rexp;
        logic [3:0]    s;
        logic          wr;
        logic [2:0]    eh;
        int            lat;
        extra_busy = tmo ? 1000 : extra;
        if (exp_g == 0) begin
            tick();
            chk("idle_grant", 32'(grant_o), 32'd0);
            chk("idle_strobe", 32'({read_o, write_o}), 32'd0);
            if (scramble) rand_reqs();
            return;
        end
        a = '0; wd = 32'h0; s = 4'hF; wr = 1'b0;
        case (exp_g)
            1: a = iaddr[AW-1:0];
            2: begin a = daddr[AW-1:0]; wd = dwdata; s = dsel; wr = dwrite; end
            default: begin a = aaddr[AW-1:0]; wd = awdata; s = asel; wr = awrite; end
        endcase
        rexp = ref_mem[a];
        if (wr)
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        tick();
        chk("issue_grant", 32'(grant_o), 32'(exp_g));
        chk("issue_strobe", 32'({read_o, write_o}), 32'({!wr, wr}));
        chk("issue_adr", 32'(adr_o), 32'(a));
        chk("issue_sel", 32'(sel_o), 32'(s));
        if (wr) chk("issue_dat", dat_o, wd);
        if (scramble) rand_reqs();
        lat = tmo ? TIMEOUT + 3 : 4 + extra;
        for (int c = 2; c < lat; c++) begin
            tick();
            chk("wait_quiet", 32'({ihit, dhit, ahit, err_o, read_o, write_o}), 32'd0);
            chk("wait_adr", 32'(adr_o), 32'(a));
        end
        tick();
        eh = 3'b100 >> (exp_g - 1);
        chk("done_hit", 32'({ihit, dhit, ahit}), 32'(eh));
        chk("done_err", 32'(err_o), 32'(tmo));
        chk("done_grant", 32'(grant_o), 32'd0);
        if (!wr && !tmo) begin
            if (exp_g == 1) e_idata = rexp;
            else if (exp_g == 2) e_drdata = rexp;
            else e_ardata = rexp;
        end
        chk("idata", idata, e_idata);
        chk("drdata", drdata, e_drdata);
        chk("ardata", ardata, e_ardata);
        model_last = exp_g;
        tick();
        chk("post_quiet", 32'({ihit, dhit, ahit, err_o}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        busy_left = 0; extra_busy = 0; model_last = 3;
        e_idata = 32'h0; e_drdata = 32'h0; e_ardata = 32'h0;
        for (int i = 0; i < 4096; i++) begin
            ram[i]     = (i * 32'h01010101) ^ 32'hA5A5_0000;
            ref_mem[i] = (i * 32'h01010101) ^ 32'hA5A5_0000;
        end
        ram[16] = 32'h00500093;
        ref_mem[16] = 32'h00500093;
        nRST = 1'b0; busy_i = 1'b0; dat_i = 32'h0;
        set_reqs(5'b0, 32'h0, 32'h0, 4'h0);

        vecs[0]  = '{5'b10000, 32'h010, 32'h0,        4'hF,    0, 1'b0, 1};
        vecs[1]  = '{5'b11010, 32'h100, 32'h0,        4'hF,    0, 1'b0, 2};
        vecs[2]  = '{5'b11010, 32'h100, 32'h0,        4'hF,    1, 1'b0, 3};
        vecs[3]  = '{5'b11010, 32'h100, 32'h0,        4'hF,    0, 1'b0, 1};
        vecs[4]  = '{5'b00100, 32'h200, 32'hDEADBEEF, 4'b0011, 3, 1'b0, 2};
        vecs[5]  = '{5'b01000, 32'h200, 32'h0,        4'hF,    0, 1'b0, 2};
        vecs[6]  = '{5'b00011, 32'h300, 32'h12345678, 4'hF,    0, 1'b0, 3};
        vecs[7]  = '{5'b00010, 32'h300, 32'h0,        4'hF,    2, 1'b0, 3};
        vecs[8]  = '{5'b10010, 32'h040, 32'h0,        4'hF,    0, 1'b0, 1};
        vecs[9]  = '{5'b01010, 32'h050, 32'h0,        4'hF,    0, 1'b1, 2};
        vecs[10] = '{5'b01010, 32'h050, 32'h0,        4'hF,    0, 1'b0, 3};
        vecs[11] = '{5'b00000, 32'h060, 32'h0,        4'hF,    0, 1'b0, 0};
        vecs[12] = '{5'b01100, 32'h400, 32'hCAFEF00D, 4'b1100, 1, 1'b0, 2};

        tick();
        tick();
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_strobes", 32'({read_o, write_o, ihit, dhit, ahit, err_o}), 32'd0);
        chk("rst_adr", 32'(adr_o), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_sel", 32'(sel_o), 32'd0);
        chk("rst_rdata", idata | drdata | ardata, 32'd0);
        nRST = 1'b1;

        for (int i = 0; i < 13; i++) begin
            set_reqs(vecs[i].req, vecs[i].addr, vecs[i].wdata, vecs[i].sel);
            do_txn(vecs[i].exp_grant, vecs[i].extra, vecs[i].tmo, 1'b0);
        end

        rand_reqs();
        for (int n = 0; n < 80; n++) begin
            int r;
            int w;
            r = $urandom_range(0, 11);
            w = rr_pick(model_last, {aread | awrite, dread | dwrite, iread});
            do_txn(w, r % 4, (r == 0), 1'b1);
        end

        // Reset asserted in the first WAIT cycle: everything clears at once, no hit follows.
        set_reqs(5'b11010, 32'h120, 32'h0, 4'hF);
        extra_busy = 0;
        tick();
        chk("pre_rst_grant", 32'(grant_o), 32'(rr_pick(model_last, 3'b111)));
        tick();
        nRST = 1'b0;
        #1;
        chk("arst_grant", 32'(grant_o), 32'd0);
        chk("arst_adr", 32'(adr_o), 32'd0);
        chk("arst_rdata", idata | drdata | ardata, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("arst_quiet", 32'({ihit, dhit, ahit, err_o, read_o, write_o}), 32'd0);
        end
        nRST = 1'b1;
        model_last = 3;
        e_idata = 32'h0; e_drdata = 32'h0; e_ardata = 32'h0;
        do_txn(1, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
